// File: rtl/score_bcd_converter_pkg.sv
// Shared constants and types for the score binary-to-BCD converter.
package score_bcd_converter_pkg;

  localparam int          DIGITS        = 8;
  localparam logic [31:0] BCD_SAT_LIMIT = 32'd100000000;
  localparam logic [3:0]  BCD_NINE      = 4'd9;
  // Narrower inputs cannot reach BCD_SAT_LIMIT, so the overflow compare is dropped.
  localparam int          OVF_MIN_W     = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

endpackage

// File: rtl/score_bcd_converter_if.sv
// Request/result bundle between the score counter, the converter and the display scan.
interface score_bcd_converter_if
  import score_bcd_converter_pkg::*;
#(
  parameter int W = 32
);

  // Handshake: START is a level request, taken only when the converter is idle
  // (BUSY=0, DONE=0); BIN is captured on that same edge. BUSY stays high through the
  // conversion, and DONE is a one-cycle pulse from which BCD0..BCD7 and OVF are valid.
  // Those outputs then hold until the next DONE.
  logic         START;
  logic [W-1:0] BIN;
  logic         BUSY;
  logic         DONE;
  logic         OVF;
  logic [3:0]   BCD0, BCD1, BCD2, BCD3, BCD4, BCD5, BCD6, BCD7;
  state_t       dbg_state;

  modport master (
    output START, BIN,
    input  BUSY, DONE, OVF,
    input  BCD0, BCD1, BCD2, BCD3, BCD4, BCD5, BCD6, BCD7,
    input  dbg_state
  );

  modport slave (
    input  START, BIN,
    output BUSY, DONE, OVF,
    output BCD0, BCD1, BCD2, BCD3, BCD4, BCD5, BCD6, BCD7,
    output dbg_state
  );

endinterface

// File: rtl/score_bcd_converter_bcd_digit_adj.sv
// One nibble of the double-dabble adjust: add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the 8-digit display.
module score_bcd_converter
  import score_bcd_converter_pkg::*;
#(
  parameter int W = 32
) (
  input logic                 CLK,
  input logic                 rst,
  score_bcd_converter_if.slave bus
);

  state_t                state, state_nx;
  logic [W-1:0]          shift_q, shift_nx;
  logic [4*DIGITS-1:0]   scratch_q, scratch_adj, scratch_nx;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [5:0]            cnt_q;
  logic                  ovf_pend_q, ovf_q;
  logic                  last_shift, ovf_cmp;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch_q[4*i +: 4]),
      .dout (scratch_adj[4*i +: 4])
    );
  end

  // The scratch MSB falls off the top of the digits; it is recycled into the spent
  // LSB of the shift register, which is never read again within the conversion.
  assign scratch_nx = {scratch_adj[4*DIGITS-2:0], shift_q[W-1]};
  assign shift_nx   = {shift_q[W-2:0], scratch_adj[4*DIGITS-1]};
  assign last_shift = (cnt_q == 6'(W - 1));
  assign ovf_cmp    = (W >= OVF_MIN_W) && (32'(bus.BIN) >= BCD_SAT_LIMIT);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.START) state_nx = SHIFT;
      SHIFT:   if (last_shift) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY      = (state == SHIFT);
    bus.DONE      = (state == FIN);
    bus.dbg_state = state;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            shift_q    <= bus.BIN;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= ovf_cmp;
          end
        end
        SHIFT: begin
          shift_q   <= shift_nx;
          scratch_q <= scratch_nx;
          cnt_q     <= cnt_q + 6'd1;
          // Results publish on the final shift edge, together with DONE rising.
          if (last_shift) begin
            bcd_q <= ovf_pend_q ? {DIGITS{BCD_NINE}} : scratch_nx;
            ovf_q <= ovf_pend_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.OVF  = ovf_q;
  assign bus.BCD0 = bcd_q[3:0];
  assign bus.BCD1 = bcd_q[7:4];
  assign bus.BCD2 = bcd_q[11:8];
  assign bus.BCD3 = bcd_q[15:12];
  assign bus.BCD4 = bcd_q[19:16];
  assign bus.BCD5 = bcd_q[23:20];
  assign bus.BCD6 = bcd_q[27:24];
  assign bus.BCD7 = bcd_q[31:28];

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: latency, digits, saturation, ignored requests, reset abort.
module tb_score_bcd_converter;
  import score_bcd_converter_pkg::*;

  localparam int W = 32;

  logic CLK = 1'b0;
  logic rst;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  score_bcd_converter_if #(.W(W)) bus ();

  score_bcd_converter #(.W(W)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] bcd_all;
  assign bcd_all = {bus.BCD7, bus.BCD6, bus.BCD5, bus.BCD4,
                    bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and returns the edge count to DONE and the BUSY-high cycles.
  task automatic run_one(input logic [31:0] bin, output int lat, output int busy_n);
    @(negedge CLK);
    bus.START = 1'b1;
    bus.BIN   = bin;
    @(posedge CLK);
    @(negedge CLK);
    bus.START = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!bus.DONE && lat < 100) begin
      if (bus.BUSY) busy_n++;
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int lat, busy_n, dones, res, done_k, nd, k, hold_bad;
    int t[3];
    logic [31:0] r[3];
    logic [31:0] prev;

    rst       = 1'b1;
    bus.START = 1'b0;
    bus.BIN   = '0;
    repeat (2) @(negedge CLK);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_ovf", 32'(bus.OVF), 32'd0);
    check("rst_bcd", bcd_all, 32'h0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    rst = 1'b0;

    run_one(32'd0, lat, busy_n);
    check("zero_lat", 32'(lat), 32'd32);
    check("zero_bcd", bcd_all, 32'h0);
    check("zero_ovf", 32'(bus.OVF), 32'd0);
    check("zero_busy_at_done", 32'(bus.BUSY), 32'd0);
    @(negedge CLK);
    check("zero_done_pulse", 32'(bus.DONE), 32'd0);

    run_one(32'd12345678, lat, busy_n);
    check("n1234_lat", 32'(lat), 32'd32);
    check("n1234_busy_cycles", 32'(busy_n), 32'd32);
    check("n1234_bcd", bcd_all, 32'h12345678);
    check("n1234_ovf", 32'(bus.OVF), 32'd0);

    run_one(32'd99999999, lat, busy_n);
    check("max8_bcd", bcd_all, 32'h99999999);
    check("max8_ovf", 32'(bus.OVF), 32'd0);

    run_one(32'd100000000, lat, busy_n);
    check("lim_bcd", bcd_all, 32'h99999999);
    check("lim_ovf", 32'(bus.OVF), 32'd1);

    run_one(32'hFFFFFFFF, lat, busy_n);
    check("ffff_lat", 32'(lat), 32'd32);
    check("ffff_bcd", bcd_all, 32'h99999999);
    check("ffff_ovf", 32'(bus.OVF), 32'd1);

    // Second request mid-conversion must be dropped.
    @(negedge CLK);
    bus.START = 1'b1;
    bus.BIN   = 32'd42;
    @(posedge CLK);
    @(negedge CLK);
    bus.START = 1'b0;
    dones  = 0;
    res    = 0;
    done_k = 0;
    for (int kk = 1; kk <= 60; kk++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.DONE) begin
        dones++;
        if (dones == 1) begin
          res    = int'(bcd_all);
          done_k = kk;
        end
      end
      if (kk == 9) begin
        bus.START = 1'b1;
        bus.BIN   = 32'd777;
      end
      if (kk == 10) bus.START = 1'b0;
    end
    check("ign_dones", 32'(dones), 32'd1);
    check("ign_bcd", 32'(res), 32'h42);
    check("ign_lat", 32'(done_k), 32'd32);
    check("ign_ovf", 32'(bus.OVF), 32'd0);

    // START held high: back-to-back conversions of 1, 2, 3.
    @(negedge CLK);
    bus.START = 1'b1;
    bus.BIN   = 32'd1;
    prev      = 32'h42;
    hold_bad  = 0;
    nd        = 0;
    k         = 0;
    @(posedge CLK);
    while (nd < 3 && k < 200) begin
      @(posedge CLK);
      k++;
      @(negedge CLK);
      if (bus.DONE) begin
        t[nd] = k;
        r[nd] = bcd_all;
        prev  = bcd_all;
        nd++;
        bus.BIN = 32'(nd + 1);
        if (nd == 3) bus.START = 1'b0;
      end else if (bcd_all !== prev) begin
        hold_bad++;
      end
    end
    check("held_count", 32'(nd), 32'd3);
    check("held_first_lat", 32'(t[0]), 32'd32);
    check("held_gap1", 32'(t[1] - t[0]), 32'd34);
    check("held_gap2", 32'(t[2] - t[1]), 32'd34);
    check("held_r1", r[0], 32'h1);
    check("held_r2", r[1], 32'h2);
    check("held_r3", r[2], 32'h3);
    check("held_hold", 32'(hold_bad), 32'd0);

    // Reset partway through a conversion.
    @(negedge CLK);
    bus.START = 1'b1;
    bus.BIN   = 32'd12345678;
    @(posedge CLK);
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (14) @(negedge CLK);
    check("pre_abort_busy", 32'(bus.BUSY), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.BUSY), 32'd0);
    check("abort_done", 32'(bus.DONE), 32'd0);
    check("abort_ovf", 32'(bus.OVF), 32'd0);
    check("abort_bcd", bcd_all, 32'h0);
    check("abort_state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge CLK);
    rst = 1'b0;
    run_one(32'd5, lat, busy_n);
    check("post_abort_lat", 32'(lat), 32'd32);
    check("post_abort_bcd", bcd_all, 32'h5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
